// File: rtl/jtag_pkg.sv
// Shared TAP types: state encodings, opcodes and the TAP next-state function.
package jtag_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR   = 4'h0,
      EXIT1_DR   = 4'h1,
      SHIFT_DR   = 4'h2,
      PAUSE_DR   = 4'h3,
      SELECT_IR  = 4'h4,
      UPDATE_DR  = 4'h5,
      CAPTURE_DR = 4'h6,
      SELECT_DR  = 4'h7,
      EXIT2_IR   = 4'h8,
      EXIT1_IR   = 4'h9,
      SHIFT_IR   = 4'hA,
      PAUSE_IR   = 4'hB,
      RTI        = 4'hC,
      UPDATE_IR  = 4'hD,
      CAPTURE_IR = 4'hE,
      TLR        = 4'hF
   } tap_state_e;

   localparam logic [3:0] OP_IDCODE  = 4'h1;
   localparam logic [3:0] OP_USER    = 4'h8;
   localparam logic [3:0] OP_BYPASS  = 4'hF;
   localparam logic [3:0] IR_CAPTURE = 4'b0101;

   // Standard 1149.1 state transition taken on each rising TCK edge
   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      n = TLR;
      case (s)
         TLR:        n = tms ? TLR       : RTI;
         RTI:        n = tms ? SELECT_DR : RTI;
         SELECT_DR:  n = tms ? SELECT_IR : CAPTURE_DR;
         CAPTURE_DR: n = tms ? EXIT1_DR  : SHIFT_DR;
         SHIFT_DR:   n = tms ? EXIT1_DR  : SHIFT_DR;
         EXIT1_DR:   n = tms ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:   n = tms ? EXIT2_DR  : PAUSE_DR;
         EXIT2_DR:   n = tms ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:  n = tms ? SELECT_DR : RTI;
         SELECT_IR:  n = tms ? TLR       : CAPTURE_IR;
         CAPTURE_IR: n = tms ? EXIT1_IR  : SHIFT_IR;
         SHIFT_IR:   n = tms ? EXIT1_IR  : SHIFT_IR;
         EXIT1_IR:   n = tms ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:   n = tms ? EXIT2_IR  : PAUSE_IR;
         EXIT2_IR:   n = tms ? UPDATE_IR : SHIFT_IR;
         UPDATE_IR:  n = tms ? SELECT_DR : RTI;
         default:    n = TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state register with registered one-hot state strobes.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tck_rise,
   input  logic       i_tms,
   output logic [3:0] o_state,
   output logic       o_capture_ir,
   output logic       o_shift_ir,
   output logic       o_update_ir,
   output logic       o_capture_dr,
   output logic       o_shift_dr,
   output logic       o_update_dr,
   output logic       o_tlr
);

   tap_state_e r_state;
   tap_state_e w_next;
   logic       r_capture_ir;
   logic       r_shift_ir;
   logic       r_update_ir;
   logic       r_capture_dr;
   logic       r_shift_dr;
   logic       r_update_dr;
   logic       r_tlr;

   assign w_next = tap_next(r_state, i_tms);

   // Advance the TAP on each rising TCK strobe; strobes decode the new state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= TLR;
         r_capture_ir <= 1'b0;
         r_shift_ir   <= 1'b0;
         r_update_ir  <= 1'b0;
         r_capture_dr <= 1'b0;
         r_shift_dr   <= 1'b0;
         r_update_dr  <= 1'b0;
         r_tlr        <= 1'b1;
      end else if (i_tck_rise) begin
         r_state      <= w_next;
         r_capture_ir <= (w_next == CAPTURE_IR);
         r_shift_ir   <= (w_next == SHIFT_IR);
         r_update_ir  <= (w_next == UPDATE_IR);
         r_capture_dr <= (w_next == CAPTURE_DR);
         r_shift_dr   <= (w_next == SHIFT_DR);
         r_update_dr  <= (w_next == UPDATE_DR);
         r_tlr        <= (w_next == TLR);
      end
   end

   assign o_state      = r_state;
   assign o_capture_ir = r_capture_ir;
   assign o_shift_ir   = r_shift_ir;
   assign o_update_ir  = r_update_ir;
   assign o_capture_dr = r_capture_dr;
   assign o_shift_dr   = r_shift_dr;
   assign o_update_dr  = r_update_dr;
   assign o_tlr        = r_tlr;

endmodule

// File: rtl/jtag_tap_target.sv
// JTAG TAP target: pin synchronisers, IR, IDCODE/USER/BYPASS data registers and TDO.
module jtag_tap_target
   import jtag_pkg::*;
#(
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
   parameter int          IR_LEN     = 4
)
(
   input  logic        i_sys_clk,
   input  logic        i_rst,
   input  logic        i_tck,
   input  logic        i_tms,
   input  logic        i_tdi,
   output logic        o_tdo,
   input  logic [31:0] i_user_capture_data,
   output logic [31:0] o_user_update_data,
   output logic        o_user_update_valid,
   output logic [3:0]  o_tap_state
);

   localparam logic [IR_LEN-1:0] L_IDCODE  = IR_LEN'(OP_IDCODE);
   localparam logic [IR_LEN-1:0] L_USER    = IR_LEN'(OP_USER);
   localparam logic [IR_LEN-1:0] L_CAPTURE = IR_LEN'(IR_CAPTURE);

   logic [2:0]        r_tck_sync;
   logic [1:0]        r_tms_sync;
   logic [1:0]        r_tdi_sync;
   logic              w_tck_rise;
   logic              w_tck_fall;
   logic              w_tms;
   logic              w_tdi;

   logic              w_capture_ir;
   logic              w_shift_ir;
   logic              w_update_ir;
   logic              w_capture_dr;
   logic              w_shift_dr;
   logic              w_update_dr;
   logic              w_tlr;

   logic [IR_LEN-1:0] r_ir_sr;
   logic [IR_LEN-1:0] r_ir;
   logic [31:0]       r_dr_sr;
   logic              r_bypass;
   logic              r_tdo;
   logic [31:0]       r_update_data;
   logic              r_update_valid;
   logic              w_sel_idcode;
   logic              w_sel_user;
   logic              w_sel_wide;

   // Two-flop synchronisers; the third TCK flop provides edge detection
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         r_tck_sync <= '0;
         r_tms_sync <= '0;
         r_tdi_sync <= '0;
      end else begin
         r_tck_sync <= {r_tck_sync[1:0], i_tck};
         r_tms_sync <= {r_tms_sync[0], i_tms};
         r_tdi_sync <= {r_tdi_sync[0], i_tdi};
      end
   end

   assign w_tck_rise = r_tck_sync[1] & ~r_tck_sync[2];
   assign w_tck_fall = ~r_tck_sync[1] & r_tck_sync[2];
   assign w_tms      = r_tms_sync[1];
   assign w_tdi      = r_tdi_sync[1];

   jtag_tap_fsm u_fsm (
      .i_clk        (i_sys_clk),
      .i_rst        (i_rst),
      .i_tck_rise   (w_tck_rise),
      .i_tms        (w_tms),
      .o_state      (o_tap_state),
      .o_capture_ir (w_capture_ir),
      .o_shift_ir   (w_shift_ir),
      .o_update_ir  (w_update_ir),
      .o_capture_dr (w_capture_dr),
      .o_shift_dr   (w_shift_dr),
      .o_update_dr  (w_update_dr),
      .o_tlr        (w_tlr)
   );

   // Unknown opcodes fall through to BYPASS
   assign w_sel_idcode = (r_ir == L_IDCODE);
   assign w_sel_user   = (r_ir == L_USER);
   assign w_sel_wide   = w_sel_idcode | w_sel_user;

   // IR shift register captures/shifts on rise; active IR loads on Update-IR fall or TLR
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         r_ir_sr <= '0;
         r_ir    <= L_IDCODE;
      end else begin
         if (w_tck_rise) begin
            if (w_capture_ir)
               r_ir_sr <= L_CAPTURE;
            else if (w_shift_ir)
               r_ir_sr <= {w_tdi, r_ir_sr[IR_LEN-1:1]};
         end
         if (w_tlr)
            r_ir <= L_IDCODE;
         else if (w_tck_fall && w_update_ir)
            r_ir <= r_ir_sr;
      end
   end

   // Selected data register captures or shifts on rising TCK
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         r_dr_sr  <= '0;
         r_bypass <= 1'b0;
      end else if (w_tck_rise) begin
         if (w_capture_dr) begin
            if (w_sel_idcode)
               r_dr_sr <= IDCODE_VAL;
            else if (w_sel_user)
               r_dr_sr <= i_user_capture_data;
            r_bypass <= 1'b0;
         end else if (w_shift_dr) begin
            if (w_sel_wide)
               r_dr_sr <= {w_tdi, r_dr_sr[31:1]};
            else
               r_bypass <= w_tdi;
         end
      end
   end

   // TDO presents the selected shift bit on falling TCK, zero outside Shift states
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         r_tdo <= 1'b0;
      end else if (w_tck_fall) begin
         if (w_shift_ir)
            r_tdo <= r_ir_sr[0];
         else if (w_shift_dr)
            r_tdo <= w_sel_wide ? r_dr_sr[0] : r_bypass;
         else
            r_tdo <= 1'b0;
      end
   end

   // USER update register with a single-cycle valid pulse on Update-DR fall
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         r_update_data  <= '0;
         r_update_valid <= 1'b0;
      end else begin
         r_update_valid <= 1'b0;
         if (w_tck_fall && w_update_dr && w_sel_user) begin
            r_update_data  <= r_dr_sr;
            r_update_valid <= 1'b1;
         end
      end
   end

   assign o_tdo               = r_tdo;
   assign o_user_update_data  = r_update_data;
   assign o_user_update_valid = r_update_valid;

endmodule

// File: tb/tb_jtag_tap_target.sv
// Self-checking bench for jtag_tap_target driving TCK/TMS/TDI at the pin level.
module tb_jtag_tap_target;
   import jtag_pkg::*;

   logic        i_sys_clk = 1'b0;
   logic        i_rst     = 1'b0;
   logic        i_tck     = 1'b0;
   logic        i_tms     = 1'b1;
   logic        i_tdi     = 1'b0;
   logic        o_tdo;
   logic [31:0] i_user_capture_data = '0;
   logic [31:0] o_user_update_data;
   logic        o_user_update_valid;
   logic [3:0]  o_tap_state;

   int   checks      = 0;
   int   errors      = 0;
   int   validCycles = 0;
   logic expQ[$];

   localparam logic [31:0] IDCODE = 32'h1000_0001;

   jtag_tap_target #(.IDCODE_VAL(IDCODE), .IR_LEN(4)) dut (
      .i_sys_clk           (i_sys_clk),
      .i_rst               (i_rst),
      .i_tck               (i_tck),
      .i_tms               (i_tms),
      .i_tdi               (i_tdi),
      .o_tdo               (o_tdo),
      .i_user_capture_data (i_user_capture_data),
      .o_user_update_data  (o_user_update_data),
      .o_user_update_valid (o_user_update_valid),
      .o_tap_state         (o_tap_state)
   );

   // 100 MHz system clock
   always #5 i_sys_clk = ~i_sys_clk;

   // Count every system cycle in which the update strobe is high
   always @(negedge i_sys_clk) begin
      if (o_user_update_valid === 1'b1)
         validCycles++;
   end

   // Hard stop in case the bench wedges
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One full TCK period: low phase with TMS/TDI set, sample TDO, then high phase
   task automatic applyStimulus(input logic tms, input logic tdi, output logic tdo);
      i_tms = tms;
      i_tdi = tdi;
      repeat (8) @(negedge i_sys_clk);
      tdo   = o_tdo;
      i_tck = 1'b1;
      repeat (8) @(negedge i_sys_clk);
      i_tck = 1'b0;
   endtask

   // Move from Run-Test/Idle into Shift-DR
   task automatic gotoShiftDr();
      logic b;
      applyStimulus(1'b1, 1'b0, b);
      applyStimulus(1'b0, 1'b0, b);
      applyStimulus(1'b0, 1'b0, b);
   endtask

   // Move from Run-Test/Idle into Shift-IR
   task automatic gotoShiftIr();
      logic b;
      applyStimulus(1'b1, 1'b0, b);
      applyStimulus(1'b1, 1'b0, b);
      applyStimulus(1'b0, 1'b0, b);
      applyStimulus(1'b0, 1'b0, b);
   endtask

   // Shift n bits LSB-first, leaving to Exit1 on the last bit; returns the TDO stream
   task automatic shiftReg(input int n, input logic [31:0] din, output logic [31:0] dout);
      logic b;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         applyStimulus((i == n - 1), din[i], b);
         dout[i] = b;
      end
   endtask

   // Exit1 -> Update -> Run-Test/Idle
   task automatic finishUpdate();
      logic b;
      applyStimulus(1'b1, 1'b0, b);
      applyStimulus(1'b0, 1'b0, b);
   endtask

   task automatic loadIr(input logic [3:0] op, output logic [31:0] cap);
      gotoShiftIr();
      shiftReg(4, {28'd0, op}, cap);
      finishUpdate();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(negedge i_sys_clk);
      checks++;
      if (o_tap_state !== 4'hF) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h expected %h", o_tap_state, 4'hF);
      end
      checks++;
      if (o_tdo !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_tdo: got %b expected 0", o_tdo);
      end
      checks++;
      if (o_user_update_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: got %h expected 00000000", o_user_update_data);
      end
      checks++;
      if (o_user_update_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_valid: got %b expected 0", o_user_update_valid);
      end
      i_rst = 1'b0;
      repeat (2) @(negedge i_sys_clk);
   endtask

   task automatic test_idcode(input string name);
      logic        b;
      logic        e;
      logic [31:0] obs;
      applyStimulus(1'b0, 1'b0, b);
      gotoShiftDr();
      for (int i = 0; i < 32; i++) expQ.push_back(IDCODE[i]);
      shiftReg(32, 32'h0, obs);
      finishUpdate();
      for (int i = 0; i < 32; i++) begin
         e = expQ.pop_front();
         checks++;
         if (obs[i] !== e) begin
            errors++;
            $display("[TB] FAIL %s bit %0d: got %b expected %b", name, i, obs[i], e);
         end
      end
      checks++;
      if (o_tap_state !== 4'hC) begin
         errors++;
         $display("[TB] FAIL %s_state: got %h expected c", name, o_tap_state);
      end
   endtask

   task automatic test_ir_capture(input logic [3:0] op);
      logic        e;
      logic [31:0] obs;
      for (int i = 0; i < 4; i++) expQ.push_back(IR_CAPTURE[i]);
      loadIr(op, obs);
      for (int i = 0; i < 4; i++) begin
         e = expQ.pop_front();
         checks++;
         if (obs[i] !== e) begin
            errors++;
            $display("[TB] FAIL ir_capture bit %0d: got %b expected %b", i, obs[i], e);
         end
      end
   endtask

   task automatic test_bypass(input logic [3:0] op);
      logic [7:0]  din;
      logic        e;
      logic [31:0] obs;
      int          v0;
      test_ir_capture(op);
      din = 8'b1011_0010;
      v0  = validCycles;
      gotoShiftDr();
      expQ.push_back(1'b0);
      for (int i = 1; i < 8; i++) expQ.push_back(din[i-1]);
      shiftReg(8, {24'd0, din}, obs);
      finishUpdate();
      for (int i = 0; i < 8; i++) begin
         e = expQ.pop_front();
         checks++;
         if (obs[i] !== e) begin
            errors++;
            $display("[TB] FAIL bypass_%h bit %0d: got %b expected %b", op, i, obs[i], e);
         end
      end
      checks++;
      if (validCycles !== v0) begin
         errors++;
         $display("[TB] FAIL bypass_%h_no_update: got %0d pulses expected 0", op, validCycles - v0);
      end
   endtask

   task automatic test_user_write();
      logic        e;
      logic [31:0] obs;
      logic [31:0] cap;
      int          v0;
      cap = 32'hCAFE_F00D;
      i_user_capture_data = cap;
      test_ir_capture(OP_USER);
      gotoShiftDr();
      for (int i = 0; i < 32; i++) expQ.push_back(cap[i]);
      v0 = validCycles;
      shiftReg(32, 32'hDEAD_BEEF, obs);
      finishUpdate();
      repeat (4) @(negedge i_sys_clk);
      for (int i = 0; i < 32; i++) begin
         e = expQ.pop_front();
         checks++;
         if (obs[i] !== e) begin
            errors++;
            $display("[TB] FAIL user_write_capture bit %0d: got %b expected %b", i, obs[i], e);
         end
      end
      checks++;
      if (o_user_update_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL user_write_data: got %h expected deadbeef", o_user_update_data);
      end
      checks++;
      if (validCycles - v0 !== 1) begin
         errors++;
         $display("[TB] FAIL user_write_pulse: got %0d cycles expected 1", validCycles - v0);
      end
   endtask

   task automatic test_user_read();
      logic        e;
      logic [31:0] obs;
      logic [31:0] cap;
      cap = 32'h1234_5678;
      i_user_capture_data = cap;
      gotoShiftDr();
      i_user_capture_data = 32'hFFFF_FFFF;
      for (int i = 0; i < 32; i++) expQ.push_back(cap[i]);
      shiftReg(32, 32'hA5A5_0F0F, obs);
      finishUpdate();
      repeat (4) @(negedge i_sys_clk);
      for (int i = 0; i < 32; i++) begin
         e = expQ.pop_front();
         checks++;
         if (obs[i] !== e) begin
            errors++;
            $display("[TB] FAIL user_read bit %0d: got %b expected %b", i, obs[i], e);
         end
      end
      checks++;
      if (o_user_update_data !== 32'hA5A5_0F0F) begin
         errors++;
         $display("[TB] FAIL user_read_update: got %h expected a5a50f0f", o_user_update_data);
      end
   endtask

   task automatic test_abort_tms();
      logic b;
      int   v0;
      test_ir_capture(OP_BYPASS);
      gotoShiftDr();
      v0 = validCycles;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, b);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, b);
      repeat (8) @(negedge i_sys_clk);
      checks++;
      if (o_tap_state !== 4'hF) begin
         errors++;
         $display("[TB] FAIL abort_state: got %h expected f", o_tap_state);
      end
      checks++;
      if (validCycles !== v0) begin
         errors++;
         $display("[TB] FAIL abort_no_update: got %0d pulses expected 0", validCycles - v0);
      end
      checks++;
      if (o_user_update_data !== 32'hA5A5_0F0F) begin
         errors++;
         $display("[TB] FAIL abort_data_hold: got %h expected a5a50f0f", o_user_update_data);
      end
      test_idcode("abort_idcode");
   endtask

   task automatic test_reset_midshift();
      logic b;
      int   v0;
      i_user_capture_data = 32'hFFFF_FFFF;
      test_ir_capture(OP_USER);
      gotoShiftDr();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, b);
      repeat (6) @(negedge i_sys_clk);
      v0 = validCycles;
      checks++;
      if (o_tdo !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midshift_tdo_before: got %b expected 1", o_tdo);
      end
      i_rst = 1'b1;
      @(negedge i_sys_clk);
      checks++;
      if (o_tap_state !== 4'hF) begin
         errors++;
         $display("[TB] FAIL midshift_state: got %h expected f", o_tap_state);
      end
      checks++;
      if (o_tdo !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midshift_tdo: got %b expected 0", o_tdo);
      end
      checks++;
      if (o_user_update_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midshift_data: got %h expected 00000000", o_user_update_data);
      end
      checks++;
      if (o_user_update_valid !== 1'b0 || validCycles !== v0) begin
         errors++;
         $display("[TB] FAIL midshift_valid: got %b (%0d pulses) expected 0", o_user_update_valid, validCycles - v0);
      end
      i_rst = 1'b0;
      repeat (4) @(negedge i_sys_clk);
      test_idcode("post_reset_idcode");
   endtask

   initial begin
      repeat (2) @(negedge i_sys_clk);
      test_reset();
      test_idcode("idcode");
      test_ir_capture(OP_BYPASS);
      test_bypass(OP_BYPASS);
      test_bypass(4'h3);
      test_user_write();
      test_user_read();
      test_abort_tms();
      test_reset_midshift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
